// File: rtl/uart_apb_pkg.sv
// Shared register map and bit positions for the APB UART FIFO front-end.
// The optional RXTHR register is enabled by UART_APB_RXTHR_EN.
package uart_apb_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_TXDATA = 5'h08;
    localparam logic [4:0] OFF_RXDATA = 5'h0C;
    localparam logic [4:0] OFF_BAUD   = 5'h10;
    localparam logic [4:0] OFF_RXTHR  = 5'h14;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_TXIE     = 1;
    localparam int unsigned CTRL_RXIE     = 2;
    localparam int unsigned CTRL_TX_FLUSH = 3;
    localparam int unsigned CTRL_RX_FLUSH = 4;

    localparam int unsigned ST_TX_EMPTY   = 0;
    localparam int unsigned ST_TX_FULL    = 1;
    localparam int unsigned ST_RX_EMPTY   = 2;
    localparam int unsigned ST_RX_FULL    = 3;
    localparam int unsigned ST_RX_OVR     = 4;
    localparam int unsigned ST_TX_CNT_LSB = 8;
    localparam int unsigned ST_RX_CNT_LSB = 16;

    // A zero divisor would stall the bit engines, so it is stored as 1.
    function automatic logic [15:0] baud_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO succeeds only alongside a pop,
// and a pop of an empty FIFO is ignored. Flush has priority over push and pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_uart_fifo_ctrl.sv
// APB3 register front-end for the UART: TX/RX FIFOs, baud divisor, maskable interrupt.
// Define UART_APB_RXTHR_EN to add the RXTHR threshold register at 0x14.
module apb_uart_fifo_ctrl
    import uart_apb_pkg::*;
#(
    parameter int unsigned DATA_W           = DATA_W_DEF,
    parameter int unsigned TX_DEPTH         = 16,
    parameter int unsigned RX_DEPTH         = 16,
    parameter int unsigned CLKS_PER_BIT_DEF = 868
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [31:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irqreq,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [15:0]       baud_div
);
    localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RXCW = $clog2(RX_DEPTH) + 1;

    logic [4:0]        addr;
    logic              wr_stb, rd_stb;
    logic              en_q, en_d, txie_q, txie_d, rxie_q, rxie_d;
    logic              ovr_q, ovr_d;
    logic [15:0]       baud_q, baud_d;

    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [TXCW-1:0]   tx_count;
    logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty, rx_drop;
    logic [DATA_W-1:0] rx_head;
    logic [RXCW-1:0]   rx_count;
    logic              rx_term;
    logic [31:0]       status;

    logic              unused_bits;
    assign unused_bits = ^{PADDR[31:5], PWDATA[31:16]};

    assign addr   = PADDR[4:0];
    assign wr_stb = PSEL & PENABLE & PWRITE;
    assign rd_stb = PSEL & PENABLE & ~PWRITE;
    assign PREADY = 1'b1;

    assign tx_valid = en_q & ~tx_empty;
    assign tx_data  = tx_valid ? tx_head : '0;
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_push  = wr_stb & (addr == OFF_TXDATA);
    assign tx_flush = wr_stb & (addr == OFF_CTRL) & PWDATA[CTRL_TX_FLUSH];

    assign rx_push  = rx_valid & en_q;
    assign rx_pop   = rd_stb & (addr == OFF_RXDATA);
    assign rx_flush = wr_stb & (addr == OFF_CTRL) & PWDATA[CTRL_RX_FLUSH];
    // A read in the same cycle frees a slot, so a full FIFO only overflows without one.
    assign rx_drop  = rx_push & rx_full & ~rx_pop & ~rx_flush;

    assign baud_div = baud_q;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (tx_push),
        .wdata_i (PWDATA[DATA_W-1:0]),
        .pop_i   (tx_pop),
        .flush_i (tx_flush),
        .rdata_o (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (rx_push),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .flush_i (rx_flush),
        .rdata_o (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

`ifdef UART_APB_RXTHR_EN
    logic [7:0] rxthr_q, rxthr_d;
    logic [7:0] rxthr_eff;
    assign rxthr_eff = (rxthr_q == 8'd0) ? 8'd1 : rxthr_q;
    assign rx_term   = (32'(rx_count) >= 32'(rxthr_eff));

    always_comb begin
        rxthr_d = rxthr_q;
        if (wr_stb && addr == OFF_RXTHR) rxthr_d = PWDATA[7:0];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) rxthr_q <= 8'd1;
        else        rxthr_q <= rxthr_d;
    end
`else
    assign rx_term = ~rx_empty;
`endif

    assign irqreq = (txie_q & tx_empty) | (rxie_q & rx_term) | ovr_q;

    always_comb begin
        en_d   = en_q;
        txie_d = txie_q;
        rxie_d = rxie_q;
        baud_d = baud_q;
        ovr_d  = ovr_q;
        if (wr_stb && addr == OFF_CTRL) begin
            en_d   = PWDATA[CTRL_EN];
            txie_d = PWDATA[CTRL_TXIE];
            rxie_d = PWDATA[CTRL_RXIE];
        end
        if (wr_stb && addr == OFF_BAUD) baud_d = baud_sanitize(PWDATA[15:0]);
        if (wr_stb && addr == OFF_STATUS && PWDATA[ST_RX_OVR]) ovr_d = 1'b0;
        if (rx_drop) ovr_d = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q   <= 1'b0;
            txie_q <= 1'b0;
            rxie_q <= 1'b0;
            ovr_q  <= 1'b0;
            baud_q <= 16'(CLKS_PER_BIT_DEF);
        end else begin
            en_q   <= en_d;
            txie_q <= txie_d;
            rxie_q <= rxie_d;
            ovr_q  <= ovr_d;
            baud_q <= baud_d;
        end
    end

    always_comb begin
        status                             = '0;
        status[ST_TX_EMPTY]                = tx_empty;
        status[ST_TX_FULL]                 = tx_full;
        status[ST_RX_EMPTY]                = rx_empty;
        status[ST_RX_FULL]                 = rx_full;
        status[ST_RX_OVR]                  = ovr_q;
        status[ST_TX_CNT_LSB +: 8]         = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8]         = 8'(rx_count);
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (addr)
                OFF_CTRL: begin
                    PRDATA[CTRL_EN]   = en_q;
                    PRDATA[CTRL_TXIE] = txie_q;
                    PRDATA[CTRL_RXIE] = rxie_q;
                end
                OFF_STATUS: PRDATA = status;
                OFF_RXDATA: PRDATA = rx_empty ? 32'd0 : 32'(rx_head);
                OFF_BAUD:   PRDATA = 32'(baud_q);
`ifdef UART_APB_RXTHR_EN
                OFF_RXTHR:  PRDATA = 32'(rxthr_q);
`endif
                default:    PRDATA = '0;
            endcase
        end
    end

    // The dropped TX push only counts as an error when no engine pop frees a slot.
    assign PSLVERR = (wr_stb & (addr == OFF_TXDATA) & tx_full & ~tx_pop)
                   | (rd_stb & (addr == OFF_RXDATA) & rx_empty);

endmodule

// File: tb/tb_apb_uart_fifo_ctrl.sv
// Self-checking bench for apb_uart_fifo_ctrl: directed scenarios plus a randomized
// mix of APB and engine traffic checked against a queue-based model.
module tb_apb_uart_fifo_ctrl;
    localparam int DEPTH = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR, irqreq;
    logic        tx_valid, tx_ready, rx_valid;
    logic [7:0]  tx_data, rx_data;
    logic [15:0] baud_div;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    bit m_en, m_txie, m_rxie, m_ovr;

    always #5 PCLK = ~PCLK;

    apb_uart_fifo_ctrl dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .irqreq   (irqreq),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .baud_div (baud_div)
    );

    function automatic logic [31:0] model_status();
        logic [31:0] s = 0;
        s[0] = (m_tx.size() == 0);
        s[1] = (m_tx.size() == DEPTH);
        s[2] = (m_rx.size() == 0);
        s[3] = (m_rx.size() == DEPTH);
        s[4] = m_ovr;
        s[15:8]  = 8'(m_tx.size());
        s[23:16] = 8'(m_rx.size());
        return s;
    endfunction

    function automatic bit model_irq();
        return (m_txie && m_tx.size() == 0) || (m_rxie && m_rx.size() != 0) || m_ovr;
    endfunction

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(posedge PCLK) #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK) #1;
        PENABLE = 1;
        #3 err = PSLVERR;
        @(posedge PCLK) #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, input bit pulse, input logic [7:0] pd,
                            output logic [31:0] rd, output logic err);
        @(posedge PCLK) #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK) #1;
        PENABLE = 1;
        if (pulse) begin rx_valid = 1; rx_data = pd; end
        #3 rd = PRDATA; err = PSLVERR;
        @(posedge PCLK) #1;
        PSEL = 0; PENABLE = 0; rx_valid = 0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge PCLK) #1;
        rx_valid = 1; rx_data = d;
        @(posedge PCLK) #1;
        rx_valid = 0;
        if (m_en) begin
            if (m_rx.size() < DEPTH) m_rx.push_back(d);
            else m_ovr = 1;
        end
    endtask

    task automatic do_reset();
        PRESET = 1;
        @(posedge PCLK) #1;
        PRESET = 0;
        m_tx.delete(); m_rx.delete();
        m_en = 0; m_txie = 0; m_rxie = 0; m_ovr = 0;
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        logic e;
        apb_write(32'h00, v, e);
        m_en = v[0]; m_txie = v[1]; m_rxie = v[2];
        if (v[3]) m_tx.delete();
        if (v[4]) m_rx.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e;
        do_reset();
        #3;
        chk_cnt++; if (PRDATA !== 0 || PSLVERR !== 0 || irqreq !== 0)
            $display("FAIL reset_outs: prdata=%h pslverr=%b irq=%b, want 0/0/0", PRDATA, PSLVERR, irqreq);
        else pass_cnt++;
        chk_cnt++; if (tx_valid !== 0 || tx_data !== 0 || baud_div !== 16'd868)
            $display("FAIL reset_tx: valid=%b data=%h baud=%0d, want 0/0/868", tx_valid, tx_data, baud_div);
        else pass_cnt++;
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd !== 32'h5) $display("FAIL reset_status: got %h want 00000005", rd);
        else pass_cnt++;
        apb_read(32'h10, 0, 0, rd, e);
        chk_cnt++; if (rd !== 32'd868) $display("FAIL reset_baud: got %0d want 868", rd);
        else pass_cnt++;
    endtask

    task automatic test_tx_basic();
        logic [31:0] rd; logic e;
        set_ctrl(32'h1);
        apb_write(32'h08, 32'h41, e);
        chk_cnt++; if (tx_valid !== 1) $display("FAIL tx_valid_latency: got %b want 1", tx_valid);
        else pass_cnt++;
        apb_write(32'h08, 32'h42, e);
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (tx_valid !== 1 || tx_data !== 8'h41 || rd[15:8] !== 8'd2)
            $display("FAIL tx_head: valid=%b data=%h cnt=%0d, want 1/41/2", tx_valid, tx_data, rd[15:8]);
        else pass_cnt++;
        @(posedge PCLK) #1; tx_ready = 1;
        #4;
        chk_cnt++; if (tx_data !== 8'h41) $display("FAIL tx_pop1: got %h want 41", tx_data);
        else pass_cnt++;
        @(posedge PCLK) #1;
        #4;
        chk_cnt++; if (tx_data !== 8'h42) $display("FAIL tx_pop2: got %h want 42", tx_data);
        else pass_cnt++;
        @(posedge PCLK) #1; tx_ready = 0;
        #4;
        chk_cnt++; if (tx_valid !== 0 || tx_data !== 0)
            $display("FAIL tx_drained: valid=%b data=%h want 0/00", tx_valid, tx_data);
        else pass_cnt++;
        m_tx.delete();
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd; logic e; logic [7:0] d;
        for (int i = 0; i <= DEPTH; i++) begin
            d = 8'($urandom);
            apb_write(32'h08, {24'h0, d}, e);
            chk_cnt++; if (e !== (m_tx.size() == DEPTH))
                $display("FAIL tx_ovf_err[%0d]: got %b want %b", i, e, m_tx.size() == DEPTH);
            else pass_cnt++;
            if (m_tx.size() < DEPTH) m_tx.push_back(d);
        end
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd !== model_status()) $display("FAIL tx_full_status: got %h want %h", rd, model_status());
        else pass_cnt++;
        @(posedge PCLK) #1; tx_ready = 1;
        while (m_tx.size() > 0) begin
            #4;
            chk_cnt++; if (tx_valid !== 1 || tx_data !== m_tx[0])
                $display("FAIL tx_drain: valid=%b data=%h want 1/%h", tx_valid, tx_data, m_tx[0]);
            else pass_cnt++;
            void'(m_tx.pop_front());
            @(posedge PCLK) #1;
        end
        tx_ready = 0;
    endtask

    task automatic test_rx_overflow();
        logic [31:0] rd; logic e;
        set_ctrl(32'h5);
        for (int i = 0; i <= DEPTH; i++) rx_pulse(8'(i));
        #3;
        chk_cnt++; if (irqreq !== 1'b1 || m_ovr !== 1'b1) $display("FAIL rx_ovf_irq: got %b want 1", irqreq);
        else pass_cnt++;
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd !== model_status()) $display("FAIL rx_ovf_status: got %h want %h", rd, model_status());
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            apb_read(32'h0C, 0, 0, rd, e);
            chk_cnt++; if (rd !== {24'h0, m_rx[0]} || e !== 0)
                $display("FAIL rx_read[%0d]: got %h err=%b want %h err=0", i, rd, e, m_rx[0]);
            else pass_cnt++;
            void'(m_rx.pop_front());
        end
        apb_read(32'h0C, 0, 0, rd, e);
        chk_cnt++; if (rd !== 0 || e !== 1) $display("FAIL rx_empty_read: got %h err=%b want 0 err=1", rd, e);
        else pass_cnt++;
        apb_write(32'h04, 32'h10, e);
        m_ovr = 0;
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd !== model_status() || irqreq !== model_irq())
            $display("FAIL ovr_w1c: status=%h irq=%b want %h/%b", rd, irqreq, model_status(), model_irq());
        else pass_cnt++;
    endtask

    task automatic test_rx_concurrent();
        logic [31:0] rd; logic e; logic [7:0] d;
        for (int i = 0; i < DEPTH; i++) rx_pulse(8'($urandom));
        d = 8'($urandom);
        apb_read(32'h0C, 1, d, rd, e);
        chk_cnt++; if (rd !== {24'h0, m_rx[0]} || e !== 0)
            $display("FAIL rx_conc_data: got %h err=%b want %h err=0", rd, e, m_rx[0]);
        else pass_cnt++;
        void'(m_rx.pop_front());
        m_rx.push_back(d);
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd !== model_status()) $display("FAIL rx_conc_status: got %h want %h", rd, model_status());
        else pass_cnt++;
        while (m_rx.size() > 0) begin
            apb_read(32'h0C, 0, 0, rd, e);
            chk_cnt++; if (rd !== {24'h0, m_rx[0]}) $display("FAIL rx_conc_drain: got %h want %h", rd, m_rx[0]);
            else pass_cnt++;
            void'(m_rx.pop_front());
        end
    endtask

    task automatic test_flush_and_regs();
        logic [31:0] rd; logic e; logic [15:0] b;
        for (int i = 0; i < 3; i++) apb_write(32'h08, $urandom, e);
        set_ctrl(32'h9);
        chk_cnt++; if (tx_valid !== 0) $display("FAIL flush_valid: got %b want 0", tx_valid);
        else pass_cnt++;
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd[15:8] !== 0 || rd[0] !== 1) $display("FAIL flush_count: status=%h want tx cnt 0", rd);
        else pass_cnt++;
        apb_read(32'h00, 0, 0, rd, e);
        chk_cnt++; if (rd !== 32'h1) $display("FAIL ctrl_read: got %h want 00000001", rd);
        else pass_cnt++;
        b = 16'($urandom_range(1, 65535));
        apb_write(32'h10, {16'hABCD, b}, e);
        apb_read(32'h10, 0, 0, rd, e);
        chk_cnt++; if (rd !== {16'h0, b} || baud_div !== b) $display("FAIL baud_rw: got %h want %h", rd, b);
        else pass_cnt++;
        apb_write(32'h10, 32'h0, e);
        chk_cnt++; if (baud_div !== 16'd1) $display("FAIL baud_zero: got %0d want 1", baud_div);
        else pass_cnt++;
        apb_read(32'h18, 0, 0, rd, e);
        chk_cnt++; if (rd !== 0 || e !== 0) $display("FAIL unmapped_rd: got %h err=%b want 0/0", rd, e);
        else pass_cnt++;
        apb_write(32'h1C, 32'hFFFF_FFFF, e);
        chk_cnt++; if (e !== 0 || baud_div !== 16'd1) $display("FAIL unmapped_wr: err=%b baud=%0d", e, baud_div);
        else pass_cnt++;
        set_ctrl(32'h3);
        #3;
        chk_cnt++; if (irqreq !== 1) $display("FAIL txie_irq: got %b want 1", irqreq);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, v; logic e; logic [7:0] d;
        set_ctrl(32'h7);
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    d = 8'($urandom);
                    apb_write(32'h08, {$urandom, d} & 32'hFFFF_FFFF, e);
                    chk_cnt++; if (e !== (m_tx.size() == DEPTH))
                        $display("FAIL rnd_txwr: err=%b want %b", e, m_tx.size() == DEPTH);
                    else pass_cnt++;
                    if (m_tx.size() < DEPTH) m_tx.push_back(d);
                end
                2, 3: rx_pulse(8'($urandom));
                4: begin
                    apb_read(32'h0C, 0, 0, rd, e);
                    v = (m_rx.size() == 0) ? 32'h0 : {24'h0, m_rx[0]};
                    chk_cnt++; if (rd !== v || e !== (m_rx.size() == 0))
                        $display("FAIL rnd_rxrd: got %h err=%b want %h", rd, e, v);
                    else pass_cnt++;
                    if (m_rx.size() > 0) void'(m_rx.pop_front());
                end
                5, 6: begin
                    @(posedge PCLK) #1; tx_ready = 1;
                    #4;
                    v = (m_en && m_tx.size() > 0) ? {24'h0, m_tx[0]} : 32'h0;
                    chk_cnt++; if (tx_valid !== (m_en && m_tx.size() > 0) || {24'h0, tx_data} !== v)
                        $display("FAIL rnd_tx: valid=%b data=%h want data %h", tx_valid, tx_data, v);
                    else pass_cnt++;
                    if (m_en && m_tx.size() > 0) void'(m_tx.pop_front());
                    @(posedge PCLK) #1; tx_ready = 0;
                end
                7: begin
                    apb_read(32'h04, 0, 0, rd, e);
                    chk_cnt++; if (rd !== model_status() || irqreq !== model_irq())
                        $display("FAIL rnd_status: got %h irq=%b want %h irq=%b",
                                 rd, irqreq, model_status(), model_irq());
                    else pass_cnt++;
                end
                8: set_ctrl({29'h0, 3'($urandom_range(0, 7)) | 3'b001} ^ {31'h0, ($urandom_range(0, 5) == 0)});
                default: begin
                    v = {27'h0, 1'($urandom), 4'($urandom)};
                    apb_write(32'h04, v, e);
                    if (v[4]) m_ovr = 0;
                end
            endcase
        end
    endtask

    task automatic test_reset_midflight();
        logic e; logic [31:0] rd;
        set_ctrl(32'h1);
        apb_write(32'h08, 32'h55, e);
        apb_write(32'h08, 32'hAA, e);
        @(posedge PCLK) #1; tx_ready = 1;
        #2 PRESET = 1;
        #1;
        chk_cnt++; if (tx_valid !== 0 || tx_data !== 0 || irqreq !== 0 || baud_div !== 16'd868
                       || PRDATA !== 0 || PSLVERR !== 0)
            $display("FAIL async_reset: valid=%b data=%h irq=%b baud=%0d", tx_valid, tx_data, irqreq, baud_div);
        else pass_cnt++;
        @(posedge PCLK) #1;
        PRESET = 0; tx_ready = 0;
        m_tx.delete(); m_rx.delete(); m_en = 0; m_txie = 0; m_rxie = 0; m_ovr = 0;
        apb_read(32'h04, 0, 0, rd, e);
        chk_cnt++; if (rd !== 32'h5) $display("FAIL post_reset_status: got %h want 00000005", rd);
        else pass_cnt++;
    endtask

    initial begin
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_overflow();
        test_rx_concurrent();
        test_flush_and_regs();
        do_reset();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
